// File: rtl/ahb_svt_mem_slave_if.sv
// AHB slave-side bus bundle for the memory responder: address/control,
// write data and bus-level ready in, slave ready, response and read data out.
interface ahb_svt_mem_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  hsel;
    logic [ADDR_WIDTH-1:0] haddr;
    logic [1:0]            htrans;
    logic                  hwrite;
    logic [2:0]            hsize;
    logic [2:0]            hburst;
    logic [3:0]            hprot;
    logic [DATA_WIDTH-1:0] hwdata;
    logic                  hready;
    logic                  hreadyout;
    logic [1:0]            hresp;
    logic [DATA_WIDTH-1:0] hrdata;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hready,
        input  hreadyout, hresp, hrdata
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hburst, hprot, hwdata, hready,
        output hreadyout, hresp, hrdata
    );
endinterface

// File: rtl/ahb_svt_mem_slave.sv
// AHB slave memory responder: decodes transfers, inserts fixed wait states,
// stores/returns little-endian data and issues the two-cycle ERROR response.
module ahb_svt_mem_slave #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic             hclk,
    input  logic             hreset,
    ahb_svt_mem_slave_if.slave bus
);
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int HI_W  = ADDR_WIDTH - 2;
    localparam logic [HI_W-1:0] DEPTH_LIM = HI_W'(MEM_DEPTH);
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

    state_t                state_reg;
    logic [3:0]            wait_cnt_reg;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  write_q;
    logic [2:0]            size_q;
    logic                  dphase_reg;
    logic                  hreadyout_reg;
    logic [1:0]            hresp_reg;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic             accept;
    logic             size_err;
    logic             align_err;
    logic             range_err;
    logic             xfer_err;
    logic             commit;
    logic [IDX_W-1:0] word_idx;
    logic [3:0]       lane_en;
    logic             unused_bits;

    // New transfers are only taken when the previous data phase is finishing.
    assign accept = ((state_reg == ST_IDLE) || (state_reg == ST_ERR2)) &
                    bus.hsel & bus.hready & bus.htrans[1];

    assign size_err  = (bus.hsize >= 3'd3);
    assign align_err = ((bus.hsize == 3'd1) && bus.haddr[0]) ||
                       ((bus.hsize == 3'd2) && (bus.haddr[1:0] != 2'b00));
    assign range_err = (bus.haddr[ADDR_WIDTH-1:2] >= DEPTH_LIM);
    assign xfer_err  = size_err | align_err | range_err;

    assign word_idx = addr_q[IDX_W+1:2];
    // A legal data phase that is in IDLE has reached its completion cycle.
    assign commit   = dphase_reg & write_q & (state_reg == ST_IDLE);

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam logic [1:0] LANE = 2'(gi);
        assign lane_en[gi] = (size_q == 3'd2) ||
                             ((size_q == 3'd1) && (addr_q[1] == LANE[1])) ||
                             ((size_q == 3'd0) && (addr_q[1:0] == LANE));
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_reg     <= ST_IDLE;
            wait_cnt_reg  <= 4'd0;
            addr_q        <= '0;
            write_q       <= 1'b0;
            size_q        <= 3'd0;
            dphase_reg    <= 1'b0;
            hreadyout_reg <= 1'b1;
            hresp_reg     <= RESP_OKAY;
        end else begin
            case (state_reg)
                ST_IDLE, ST_ERR2: begin
                    if (accept) begin
                        addr_q  <= bus.haddr;
                        write_q <= bus.hwrite;
                        size_q  <= bus.hsize;
                        if (xfer_err) begin
                            state_reg     <= ST_ERR1;
                            dphase_reg    <= 1'b0;
                            hreadyout_reg <= 1'b0;
                            hresp_reg     <= RESP_ERROR;
                        end else if (WAIT_STATES > 0) begin
                            state_reg     <= ST_WAIT;
                            wait_cnt_reg  <= 4'(WAIT_STATES);
                            dphase_reg    <= 1'b1;
                            hreadyout_reg <= 1'b0;
                            hresp_reg     <= RESP_OKAY;
                        end else begin
                            state_reg     <= ST_IDLE;
                            dphase_reg    <= 1'b1;
                            hreadyout_reg <= 1'b1;
                            hresp_reg     <= RESP_OKAY;
                        end
                    end else begin
                        state_reg     <= ST_IDLE;
                        dphase_reg    <= 1'b0;
                        hreadyout_reg <= 1'b1;
                        hresp_reg     <= RESP_OKAY;
                    end
                end
                ST_WAIT: begin
                    wait_cnt_reg <= wait_cnt_reg - 4'd1;
                    if (wait_cnt_reg <= 4'd1) begin
                        state_reg     <= ST_IDLE;
                        hreadyout_reg <= 1'b1;
                    end
                end
                ST_ERR1: begin
                    state_reg     <= ST_ERR2;
                    hreadyout_reg <= 1'b1;
                    hresp_reg     <= RESP_ERROR;
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    hreadyout_reg <= 1'b1;
                    hresp_reg     <= RESP_OKAY;
                end
            endcase
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_en[b]) begin
                    mem[word_idx][b*8 +: 8] <= bus.hwdata[b*8 +: 8];
                end
            end
        end
    end

    // Read data is combinational so a write committing at the previous edge is visible.
    assign bus.hrdata    = (dphase_reg && !write_q) ? mem[word_idx] : '0;
    assign bus.hreadyout = hreadyout_reg;
    assign bus.hresp     = hresp_reg;

    assign unused_bits = ^{bus.hburst, bus.hprot, bus.htrans[0],
                           addr_q[ADDR_WIDTH-1:IDX_W+2]};
endmodule
